// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, word type and index-width helper for the data memory
package dmem_pkg;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_ADDR_W = 32;
  typedef logic [DMEM_DATA_W-1:0] word_t;
  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with synchronous write, clear-all on reset and asynchronous read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int DEPTH_WORDS = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we,
  input  logic [idx_w(DEPTH_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[idx] <= wdata;
    end
  end
  assign rdata = mem_q[idx];
endmodule

// File: rtl/data_mem.sv
// data_mem: MEM-stage data memory, async read / sync write; DMEM_ALIGN_CHECK_EN adds misalign and blocks misaligned stores
module data_mem
  import dmem_pkg::*;
#(
  parameter int DATA_W      = DMEM_DATA_W,
  parameter int ADDR_W      = DMEM_ADDR_W,
  parameter int DEPTH_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] rdata
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);
  localparam int IW = idx_w(DEPTH_WORDS);
  logic [IW-1:0]     idx;
  logic              we;
  logic [DATA_W-1:0] word;
  logic              unused_addr;
`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (mem_read | mem_write) & (addr[1:0] != 2'b00);
`endif
  // upper bits wrap the address space, low two bits select a byte within the word
  assign unused_addr = ^{addr[ADDR_W-1:IW+2], addr[1:0]};
  always_comb begin
    idx = addr[2 +: IW];
`ifdef DMEM_ALIGN_CHECK_EN
    we = mem_write & rst_n & ~misalign;
`else
    we = mem_write & rst_n;
`endif
    rdata = (mem_read & rst_n) ? word : '0;
  end
  dmem_array #(
    .DATA_W     (DATA_W),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (we),
    .idx  (idx),
    .wdata(wdata),
    .rdata(word)
  );
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed scenarios plus random traffic checked against an array model of the memory
module tb_data_mem;
  import dmem_pkg::*;
  localparam int DEPTH = 256;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        mem_read = 0;
  logic        mem_write = 0;
  logic [31:0] addr = '0;
  word_t       wdata = '0;
  word_t       rdata;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        misalign;
`endif
  word_t ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wdata    (wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .rdata    (rdata)
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    .misalign (misalign)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one access, check the pre-edge outputs, then let the model take the edge
  task automatic step(input string tag, input logic r, input logic rd, input logic wr,
                      input logic [31:0] a, input word_t d);
    int  i;
    bit  store_ok;
    @(negedge clk);
    rst_n = r; mem_read = rd; mem_write = wr; addr = a; wdata = d;
    #1;
    i = int'((a / 4) % DEPTH);
    check_eq(tag, rdata, (rd && r) ? ref_mem[i] : '0);
    store_ok = 1;
`ifdef DMEM_ALIGN_CHECK_EN
    check_eq({tag, "_mis"}, {31'b0, misalign}, {31'b0, (rd || wr) && (a % 4 != 0)});
    store_ok = (a % 4 == 0);
`endif
    @(posedge clk);
    if (!r) foreach (ref_mem[k]) ref_mem[k] = '0;
    else if (wr && store_ok) ref_mem[i] = d;
  endtask

  initial begin
    step("rst_rd", 0, 1, 0, 32'h40, '0);
    step("rst_rd2", 0, 1, 0, 32'h40, '0);
    step("post_rst_rd", 1, 1, 0, 32'h40, '0);
    #1 check_eq("post_rst_zero", rdata, 32'h0);

    step("st", 1, 0, 1, 32'h10, 32'hDEADBEEF);
    step("ld", 1, 1, 0, 32'h10, '0);
    #1 check_eq("ld_const", rdata, 32'hDEADBEEF);
    step("ld_off", 1, 0, 0, 32'h10, '0);
    #1 check_eq("ld_off_const", rdata, 32'h0);

    step("st5", 1, 0, 1, 32'h20, 32'd5);
    step("rw_old", 1, 1, 1, 32'h20, 32'd9);
    #1 check_eq("rw_new", rdata, 32'd9);

    step("wrap_st", 1, 0, 1, DEPTH * 4 + 8, 32'h1234);
    step("wrap_ld", 1, 1, 0, 32'h8, '0);
    #1 check_eq("wrap_const", rdata, 32'h1234);

    step("rst_wr", 0, 0, 1, 32'h30, 32'hFF);
    step("rst_ld10", 1, 1, 0, 32'h10, '0);
    #1 check_eq("rst_ld10_const", rdata, 32'h0);
    step("rst_ld30", 1, 1, 0, 32'h30, '0);
    #1 check_eq("rst_ld30_const", rdata, 32'h0);

    step("pre_mis", 1, 0, 1, 32'h10, 32'hAA);
    step("mis_st", 1, 0, 1, 32'h11, 32'd7);
    step("mis_ld", 1, 1, 0, 32'h10, '0);
`ifdef DMEM_ALIGN_CHECK_EN
    #1 check_eq("mis_const", rdata, 32'hAA);
`else
    #1 check_eq("mis_const", rdata, 32'd7);
`endif

    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
      step("rand", $urandom_range(0, 63) != 0, 1'($urandom), 1'($urandom), a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
